// File: rtl/knn_stream_loader.sv
// knn_stream_loader: word-serial front/back end for the combinational k-NN core.
// Shifts the query plus N points into a packed bus, waits LAT cycles for the
// core to settle, captures its K-word result and streams it out MSB word first.
module knn_stream_loader #(
    parameter int W   = 32,
    parameter int K   = 2,
    parameter int N   = 4,
    parameter int LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    output logic [(N+1)*W-1:0]   p_input,
    input  logic [K*W-1:0]       core_o,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int WCW = $clog2(N + 1);
    localparam int SCW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int RW  = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        SEND
    } state_t;

    state_t               state_q, state_d;
    logic [WCW-1:0]       wc_q, wc_d;
    logic [SCW-1:0]       sc_q, sc_d;
    logic [RW-1:0]        r_q, r_d;
    logic [(N+1)*W-1:0]   p_q, p_d;
    logic [K*W-1:0]       res_q, res_d;
    logic [W-1:0]         out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;

    assign in_ready  = (state_q == LOAD) && rst_n;
    assign busy      = (state_q != LOAD);
    assign p_input   = p_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    // Next-state and datapath: load shifting, settle counting, result streaming.
    // The result register shifts left one word per handshake so the next word
    // to send is always in its top slot; out_data itself is a separate flop.
    always_comb begin
        state_d     = state_q;
        wc_d        = wc_q;
        sc_d        = sc_q;
        r_d         = r_q;
        p_d         = p_q;
        res_d       = res_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    p_d = {p_q[N*W-1:0], in_data};
                    if (wc_q == WCW'(N)) begin
                        wc_d    = '0;
                        sc_d    = '0;
                        state_d = SETTLE;
                    end else begin
                        wc_d = wc_q + WCW'(1);
                    end
                end
            end
            SETTLE: begin
                if (sc_q == SCW'(LAT - 1)) begin
                    res_d       = core_o << W;
                    out_data_d  = core_o[K*W-1 -: W];
                    out_last_d  = (K == 1);
                    out_valid_d = 1'b1;
                    r_d         = '0;
                    state_d     = SEND;
                end else begin
                    sc_d = sc_q + SCW'(1);
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (r_q == RW'(K - 1)) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        r_d         = '0;
                        state_d     = LOAD;
                    end else begin
                        r_d        = r_q + RW'(1);
                        out_data_d = res_q[K*W-1 -: W];
                        res_d      = res_q << W;
                        out_last_d = (r_q + RW'(1) == RW'(K - 1));
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            wc_q        <= '0;
            sc_q        <= '0;
            r_q         <= '0;
            p_q         <= '0;
            res_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wc_q        <= wc_d;
            sc_q        <= sc_d;
            r_q         <= r_d;
            p_q         <= p_d;
            res_q       <= res_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_knn_stream_loader.sv
// Testbench for knn_stream_loader: main config W=8,K=2,N=4,LAT=2 plus a
// K=1,N=1,LAT=1 corner instance. Expected output words go into a scoreboard
// queue when core_o is driven and are popped as the DUT hands them out.
module tb_knn_stream_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [39:0] p_input;
    logic [15:0] core_o = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    logic        c_in_valid = 1'b0;
    logic        c_in_ready;
    logic [7:0]  c_in_data = '0;
    logic [15:0] c_p_input;
    logic [7:0]  c_core_o = '0;
    logic        c_out_valid;
    logic        c_out_ready = 1'b0;
    logic [7:0]  c_out_data;
    logic        c_out_last;
    logic        c_busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [8:0] sb[$];
    logic [7:0] basic_words [5] = '{8'h10, 8'h11, 8'h22, 8'h33, 8'h44};
    localparam logic [39:0] BASIC_P = 40'h1011223344;

    knn_stream_loader #(.W(8), .K(2), .N(4), .LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .p_input(p_input), .core_o(core_o),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    knn_stream_loader #(.W(8), .K(1), .N(1), .LAT(1)) u_corner (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .p_input(c_p_input), .core_o(c_core_o),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_last(c_out_last), .busy(c_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one word and wait (bounded) for it to be accepted; edge_n is the
    // cycle number of the accepting edge. Returns at #1 after that edge.
    task automatic load_word(input logic [7:0] d, output int edge_n);
        logic hs;
        hs = 1'b0;
        edge_n = -1;
        in_valid = 1'b1;
        in_data = d;
        for (int i = 0; i < 50; i++) begin
            hs = in_ready;
            @(posedge clk); #1;
            if (hs) begin
                edge_n = cyc;
                break;
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (!hs) begin
            miscompares++;
            $display("FAIL load_timeout: in_ready=%0b required=1 for word %02h", in_ready, d);
        end
    endtask

    task automatic load_basic(input int gap, output int t_last);
        for (int i = 0; i < 5; i++) begin
            load_word(basic_words[i], t_last);
            for (int g = 0; g < gap && i < 4; g++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({in_ready, busy, out_valid, out_last} !== 4'b0000 || p_input !== 40'h0 || out_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: rdy/busy/ov/last=%b p=%h od=%h required 0000 0 00",
                     {in_ready, busy, out_valid, out_last}, p_input, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_basic_result();
        int t, n;
        logic [8:0] exp;
        load_basic(0, t);
        vectors++;
        if (p_input !== BASIC_P || in_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_load: p=%h rdy=%b busy=%b required %h 0 1", p_input, in_ready, busy, BASIC_P);
        end
        core_o = 16'hABCD;
        sb.push_back({1'b0, 8'hAB});
        sb.push_back({1'b1, 8'hCD});
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 2; i++) begin
            if (out_valid) begin
                if (n == 0) begin
                    vectors++;
                    if (cyc - t !== 2) begin
                        miscompares++;
                        $display("FAIL basic_latency: got %0d edges required 2", cyc - t);
                    end
                end
                exp = (sb.size() > 0) ? sb.pop_front() : 9'h1FF;
                vectors++;
                if ({out_last, out_data} !== exp) begin
                    miscompares++;
                    $display("FAIL basic_word%0d: last/data=%b/%h required %b/%h", n, out_last, out_data, exp[8], exp[7:0]);
                end
                n++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        vectors++;
        if (n != 2 || in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done: words=%0d rdy=%b busy=%b required 2 1 0", n, in_ready, busy);
        end
    endtask

    task automatic test_backpressure();
        int t, n;
        logic [8:0] exp;
        load_basic(0, t);
        core_o = 16'hABCD;
        sb.push_back({1'b0, 8'hAB});
        sb.push_back({1'b1, 8'hCD});
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            core_o = 16'h0000;
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'hAB || out_last !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: ov/data/last=%b/%h/%b required 1/ab/0", i, out_valid, out_data, out_last);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            if (out_valid) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 9'h1FF;
                vectors++;
                if ({out_last, out_data} !== exp) begin
                    miscompares++;
                    $display("FAIL bp_word%0d: last/data=%b/%h required %b/%h", n, out_last, out_data, exp[8], exp[7:0]);
                end
                n++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        vectors++;
        if (n != 2) begin
            miscompares++;
            $display("FAIL bp_count: got %0d words required 2", n);
        end
    endtask

    task automatic test_gaps_ignore();
        int t, n;
        logic [8:0] exp;
        load_basic(2, t);
        in_valid = 1'b1;
        in_data = 8'hFF;
        core_o = 16'h5A3C;
        sb.push_back({1'b0, 8'h5A});
        sb.push_back({1'b1, 8'h3C});
        vectors++;
        if (p_input !== BASIC_P) begin
            miscompares++;
            $display("FAIL gap_load: p=%h required %h", p_input, BASIC_P);
        end
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 2; i++) begin
            if (out_valid) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 9'h1FF;
                vectors++;
                if ({out_last, out_data} !== exp) begin
                    miscompares++;
                    $display("FAIL gap_word%0d: last/data=%b/%h required %b/%h", n, out_last, out_data, exp[8], exp[7:0]);
                end
                n++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (n != 2 || p_input !== BASIC_P) begin
            miscompares++;
            $display("FAIL gap_ignore: words=%0d p=%h required 2 %h", n, p_input, BASIC_P);
        end
    endtask

    task automatic test_reset_settle();
        int t;
        load_basic(0, t);
        core_o = 16'h9876;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || p_input !== 40'h0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_settle: ov=%b p=%h busy=%b rdy=%b required 0 0 0 0", out_valid, p_input, busy, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_result: out_valid=%b required 0", out_valid);
        end
        load_basic(0, t);
        vectors++;
        if (p_input !== BASIC_P || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_reload: p=%h busy=%b required %h 1", p_input, busy, BASIC_P);
        end
        test_basic_drain_after_reset();
    endtask

    task automatic test_basic_drain_after_reset();
        int n;
        logic [8:0] exp;
        core_o = 16'hABCD;
        sb.push_back({1'b0, 8'hAB});
        sb.push_back({1'b1, 8'hCD});
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 2; i++) begin
            if (out_valid) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 9'h1FF;
                vectors++;
                if ({out_last, out_data} !== exp) begin
                    miscompares++;
                    $display("FAIL rst_word%0d: last/data=%b/%h required %b/%h", n, out_last, out_data, exp[8], exp[7:0]);
                end
                n++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        vectors++;
        if (n != 2) begin
            miscompares++;
            $display("FAIL rst_count: got %0d words required 2", n);
        end
    endtask

    task automatic test_corner();
        int t, n;
        logic [8:0] exp;
        c_core_o = 8'h07;
        c_in_valid = 1'b1;
        c_in_data = 8'h05;
        @(posedge clk); #1;
        c_in_data = 8'h07;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        t = cyc;
        sb.push_back({1'b1, 8'h07});
        vectors++;
        if (c_p_input !== 16'h0507 || c_busy !== 1'b1 || c_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL corner_load: p=%h busy=%b rdy=%b required 0507 1 0", c_p_input, c_busy, c_in_ready);
        end
        c_out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && n < 1; i++) begin
            if (c_out_valid) begin
                vectors++;
                if (cyc - t !== 1) begin
                    miscompares++;
                    $display("FAIL corner_latency: got %0d edges required 1", cyc - t);
                end
                exp = (sb.size() > 0) ? sb.pop_front() : 9'h1FF;
                vectors++;
                if ({c_out_last, c_out_data} !== exp) begin
                    miscompares++;
                    $display("FAIL corner_word: last/data=%b/%h required %b/%h", c_out_last, c_out_data, exp[8], exp[7:0]);
                end
                n++;
            end
            @(posedge clk); #1;
        end
        c_out_ready = 1'b0;
        vectors++;
        if (n != 1 || c_out_valid !== 1'b0 || c_in_ready !== 1'b1 || c_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL corner_done: words=%0d ov=%b rdy=%b busy=%b required 1 0 1 0", n, c_out_valid, c_in_ready, c_busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_result();
        test_backpressure();
        test_gaps_ignore();
        test_reset_settle();
        test_corner();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: %0d entries left required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/knn_stream_loader.md
# knn_stream_loader

Sequential front/back end for the combinational k-NN core. It accepts the query and the N candidate points one W-bit word at a time over a valid/ready stream, and assembles them into the packed `(N+1)*W` input bus the core expects. After a fixed settle interval it captures the core's `K*W` result. It then streams the K selected points back out one word per handshake, so the core can sit behind a narrow word interface.

## Interface
Parameters:
- `W`, 32, word width: coordinate/distance width of one point.
- `K`, 2, number of result words returned per query.
- `N`, 4, number of candidate points per query.
- `LAT`, 1, settle cycles allowed for the combinational core. Must be ≥1; 0 is illegal.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  W  input word: the query first, then points 0..N-1.
- `p_input`  out  (N+1)*W  packed bus to the core. Query in `[(N+1)*W-1:N*W]`; point j in `[(N-j)*W-1:(N-j-1)*W]`.
- `core_o`  in  K*W  result bus from the core.
- `out_valid`  out  1  result word valid.
- `out_ready`  in  1  downstream accepts the result word.
- `out_data`  out  W  result word.
- `out_last`  out  1  marks result word K-1.
- `busy`  out  1  high whenever the state is not LOAD.

## Operation
- FSM states: LOAD, SETTLE, SEND.
- LOAD:
  - `in_ready`=1.
  - Each `in_valid&in_ready` edge shifts the packed register: `p_input <= {p_input[N*W-1:0], in_data}`, and increments word counter `wc` (width `$clog2(N+1)`).
  - When the accepted word has `wc==N`, clear `wc` and go to SETTLE. After N+1 words the query sits in the MSB slot.
- SETTLE:
  - `p_input` is held constant.
  - Settle counter counts LAT edges.
  - On the LAT-th edge: capture `core_o` into the result register, set `out_valid`=1, load word 0, go to SEND.
- SEND:
  - Result word r (r=0..K-1) is `core_o[(K-r)*W-1:(K-r-1)*W]` as captured, MSB word first.
  - `out_last`=1 when r==K-1.
  - On an `out_valid&out_ready` edge, advance r. After word K-1: clear `out_valid`/`out_last`, go to LOAD.
  - `p_input` is held throughout SEND and is not cleared until the next query shifts in.
- `in_valid` outside LOAD is ignored and consumes nothing.
- `core_o` changes outside the capture edge have no effect on `out_data`.
- K=1: the single word carries `out_last`=1.

## Timing
- Reset (async assert, sync release) forces:
  - state=LOAD, `wc`=0, r=0;
  - `p_input`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0.
  - `in_ready`=0 while `rst_n`=0.
- `in_ready` = (state==LOAD) && `rst_n`, decoded combinationally from registered state.
- Reset mid-operation (any state) discards all partial input and pending results. The first word after release is treated as a new query.
- Input latency: N+1 accepting edges; bubbles in `in_valid` simply stall.
- Last input handshake at edge t: `busy`=1 from t, `out_valid`=1 from edge t+LAT.
- Output backpressure: while `out_valid&!out_ready`, `out_data` and `out_last` hold stable.
- After the final output handshake at edge u: `in_ready`=1 and `busy`=0 from u.
- Minimum cycles per query: N+1+LAT+K.
- `out_valid`, `out_data`, `out_last` and `p_input` are all registered; there is no combinational path from `core_o` or `out_ready` to any output.

## Test plan
Unless noted: W=8, K=2, N=4, LAT=2.
- Basic load: words 0x10,0x11,0x22,0x33,0x44 with `in_valid` always high -> `p_input`=0x1011223344, `in_ready`=0 after the fifth handshake, `busy`=1.
- Result stream: after the load, core model drives `core_o`=0xABCD -> `out_valid` rises exactly 2 edges after the last input handshake; `out_data`=0xAB with `out_last`=0, then 0xCD with `out_last`=1; `in_ready`=1 the cycle after.
- Backpressure: hold `out_ready`=0 for 3 cycles on word 0 and change `core_o` to 0x0000 meanwhile -> `out_data` stays 0xAB and the second word is still 0xCD.
- Input gaps and ignore: insert `in_valid`=0 bubbles between words, and drive `in_valid`=1 with 0xFF during SETTLE/SEND -> same `p_input` as the basic load, 0xFF never captured.
- Reset mid-SETTLE: pull `rst_n` low one cycle after the last input -> `out_valid`=0, `p_input`=0, `busy`=0 immediately; after release a fresh 5-word load behaves as the basic load.
- Corner config: K=1, N=1, LAT=1; words 0x05,0x07, `core_o`=0x07 -> `p_input`=0x0507, single output 0x07 with `out_last`=1, 1 cycle after the last input.
